spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 123 ++++++++++++
 tb/tb_spi_slave_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: 12-bit LSB-first frames sampled on sclk falls after one lead-in fall,
// with a 12-bit response shifted out on miso. All SPI inputs are resynchronized to clk.
module spi_slave_rx (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_mosi,
  input  logic [11:0] i_tx_data,
  output logic        o_miso,
  output logic [11:0] o_dout,
  output logic        o_done,
  output logic        o_frame_err
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, WAIT_END} state_t;

  state_t      r_state;
  logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic [1:0]  r_live;
  logic        r_armed;
  logic [3:0]  r_cnt;
  logic [11:0] r_rx, r_tx, r_dout;
  logic        r_done, r_err;

  logic        w_sclk_fall, w_sclk_rise, w_cs_fall, w_cs_high;
  logic [11:0] w_rx_next;

  assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
  assign w_sclk_rise = ~r_sclk_d & r_sclk_s2;
  assign w_cs_high   = r_cs_s2;
  // A frame may only start once cs has been genuinely seen high since reset.
  assign w_cs_fall   = r_armed & r_cs_d & ~r_cs_s2;
  assign w_rx_next   = {r_mosi_s2, r_rx[11:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s1 <= 1'b1; r_sclk_s2 <= 1'b1; r_sclk_d <= 1'b1;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_d   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0; r_mosi_d <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
      r_cs_s1   <= i_cs;   r_cs_s2   <= r_cs_s1;   r_cs_d   <= r_cs_s2;
      r_mosi_s1 <= i_mosi; r_mosi_s2 <= r_mosi_s1; r_mosi_d <= r_mosi_s2;
    end
  end

  // r_live[1] marks the point where r_cs_s2 holds a real sample rather than its reset value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & r_cs_s2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rx    <= 12'h000;
      r_tx    <= 12'h000;
      r_dout  <= 12'h000;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_tx    <= i_tx_data;
            r_cnt   <= 4'd0;
            r_state <= LEAD;
          end
        end
        LEAD: begin
          if (w_cs_high) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_sclk_fall) begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // The 12th fall completes the frame even if cs rises in the same cycle.
          if (w_sclk_fall && r_cnt == 4'd11) begin
            r_rx    <= w_rx_next;
            r_tx    <= {1'b0, r_tx[11:1]};
            r_cnt   <= r_cnt + 4'd1;
            r_dout  <= w_rx_next;
            r_done  <= 1'b1;
            r_state <= WAIT_END;
          end else if (w_cs_high) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_sclk_fall) begin
            r_rx  <= w_rx_next;
            r_tx  <= {1'b0, r_tx[11:1]};
            r_cnt <= r_cnt + 4'd1;
          end
        end
        WAIT_END: begin
          if (w_cs_high) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_miso      = ~r_cs_s2 & r_tx[0];
  assign o_dout      = r_dout;
  assign o_done      = r_done;
  assign o_frame_err = r_err;

  logic w_unused;
  assign w_unused = w_sclk_rise ^ r_mosi_d;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: directed frames push expected pulses, a monitor checks them.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] tx_data = 12'h000;
  logic        miso;
  logic [11:0] dout;
  logic        done, frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [11:0] dout;
  } exp_t;
  exp_t sb[$];

  spi_slave_rx dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
    .i_tx_data(tx_data), .o_miso(miso), .o_dout(dout), .o_done(done),
    .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (done || frame_err)) begin
      exp_t e;
      chk("pulse_exclusive", {11'd0, done & frame_err}, 12'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {10'd0, done, frame_err}, 12'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {11'd0, frame_err}, {11'd0, e.is_err});
        chk("dout", dout, e.dout);
      end
    end
  end

  task automatic push(input bit is_err, input logic [11:0] d);
    exp_t e;
    e.is_err = is_err;
    e.dout   = d;
    sb.push_back(e);
  endtask

  // Lead-in fall, then nfalls data falls (bits beyond 12 drive 1), then cs high for gap ns.
  task automatic frame(input logic [11:0] w, input int nfalls, input bit collide,
                       input bit chk_miso, input logic [11:0] txw, input int gap);
    cs = 1'b0; #40;
    sclk = 1'b0; #40;
    for (int i = 0; i < nfalls; i++) begin
      mosi = (i < 12) ? w[i] : 1'b1;
      sclk = 1'b1; #40;
      if (chk_miso && i < 12) chk($sformatf("miso_bit%0d", i), {11'd0, miso}, {11'd0, txw[i]});
      if (collide && i == nfalls - 1) begin
        sclk = 1'b0; cs = 1'b1;
      end else begin
        sclk = 1'b0;
      end
      #40;
    end
    sclk = 1'b1; #40;
    cs = 1'b1; #gap;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 12'h000);
    chk("rst_done", {11'd0, done}, 12'd0);
    chk("rst_err", {11'd0, frame_err}, 12'd0);
    chk("rst_miso", {11'd0, miso}, 12'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal frame with response 3C1
    tx_data = 12'h3C1;
    push(1'b0, 12'hA5C);
    frame(12'hA5C, 12, 1'b0, 1'b1, 12'h3C1, 80);
    chk("miso_idle", {11'd0, miso}, 12'd0);

    // Back-to-back with a short cs-high gap
    tx_data = 12'h000;
    push(1'b0, 12'hFFF);
    frame(12'hFFF, 12, 1'b0, 1'b0, 12'h0, 20);
    push(1'b0, 12'h001);
    frame(12'h001, 12, 1'b0, 1'b0, 12'h0, 80);

    // Early abort after 7 bits: dout keeps 001
    push(1'b1, 12'h001);
    frame(12'h123, 7, 1'b0, 1'b0, 12'h0, 80);

    // Extra clocks beyond the 12th sample are ignored
    push(1'b0, 12'h800);
    frame(12'h800, 15, 1'b0, 1'b0, 12'h0, 80);

    // Reset mid-frame after 5 bits, cs kept low through release
    @(negedge clk);
    cs = 1'b0; #40;
    sclk = 1'b0; #40;
    for (int i = 0; i < 5; i++) begin
      mosi = i[0]; sclk = 1'b1; #40; sclk = 1'b0; #40;
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_dout", dout, 12'h000);
    chk("midrst_miso", {11'd0, miso}, 12'd0);
    // cs still low from before reset: these clocks must not form a frame
    for (int i = 0; i < 13; i++) begin
      mosi = 1'b1; sclk = 1'b1; #40; sclk = 1'b0; #40;
    end
    sclk = 1'b1; #40;
    cs = 1'b1; #80;
    chk("after_stale_dout", dout, 12'h000);
    push(1'b0, 12'h7E7);
    frame(12'h7E7, 12, 1'b0, 1'b0, 12'h0, 80);

    // cs rises together with the 12th fall: completion wins
    push(1'b0, 12'h555);
    frame(12'h555, 12, 1'b1, 1'b0, 12'h0, 80);

    repeat (20) @(negedge clk);
    chk("sb_empty", sb.size() > 0 ? 12'(sb.size()) : 12'd0, 12'd0);
    chk("final_dout", dout, 12'h555);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
